mcycle_ctrl: RTL
================

// Module: mcycle_ctrl
// PURPOSE
//  Multi-cycle sequencer for the RV32I core; the next generation of the single-cycle controller.
//  - Steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
//  - Waits on the memory ready handshake (MIO_ready) and takes traps for external interrupts
//    (INT), illegal opcodes and bus timeouts; MRET returns from a trap.
//  - Drives enables and selects only; the datapath (PC, IR, RF, ALU, EPC) is external.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles mem_req may wait for MIO_ready before a bus-error trap (>=2)
//  CNT_W        5   timeout counter width; must hold MEM_TIMEOUT-1
//  INT_EN_RST   1   value of internal interrupt-enable flag after reset
// PORTS
//  clk        in   1  clock, rising edge
//  rst        in   1  synchronous reset, active-high
//  Op         in   7  instr[6:0] from IR
//  Funct3     in   3  instr[14:12]
//  Funct7     in   7  instr[31:25]
//  zf,sf,cf,of in  1  ALU flags for A-B (cf=borrow), valid in EXEC
//  MIO_ready  in   1  memory completes the current mem_req this cycle
//  INT        in   1  external interrupt request, level
//  mem_req    out  1  memory access active (FETCH, MEM)
//  mem_we     out  1  store access (MEM state, store only)
//  ir_we      out  1  latch instruction (FETCH & MIO_ready)
//  pc_we      out  1  commit NPC to PC
//  npc_sel    out  3  0 PC+4, 1 PC+imm, 2 aluout&~1, 3 trap vector, 4 EPC
//  rf_we      out  1  register-file write (WB, rd!=0 gating is in RF)
//  wb_sel     out  2  0 aluout, 1 readdata, 2 PC+4
//  epc_we     out  1  save PC into EPC (TRAP state)
//  cause      out  2  0 none, 1 interrupt, 2 illegal, 3 bus error; valid when epc_we=1
//  int_ack    out  1  1-cycle ack in TRAP when cause=1
//  state      out  3  current state, for debug
// BEHAVIOUR
//  Reset: state<=FETCH(0), cnt<=0, int_en<=INT_EN_RST, cause reg<=0.
//   - While rst=1, all outputs are forced 0 (state also reads 0).
//  States: FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 TRAP=5; codes 6,7 go to FETCH next cycle.
//  Outputs are Moore decodes of the state, qualified by registered opcode class and MIO_ready.
//  FETCH: mem_req=1.
//   - MIO_ready=1 -> ir_we=1, next DECODE.
//   - Otherwise cnt++; when cnt==MEM_TIMEOUT-1 with no ready -> TRAP, cause 3.
//  DECODE (1 cycle): legal ops are 0110011, 0010011, 0000011, 0100011, 1100011, 1101111,
//   1100111, 0110111, 0010111, and 1110011 with Funct3=000 & Funct7=0011000 (MRET).
//   - Branch Funct3 010/011 is illegal.
//   - Illegal -> TRAP, cause 2; else -> EXEC.
//  EXEC:
//   - Load/store -> MEM.
//   - R/I/LUI/AUIPC/JAL/JALR -> WB.
//   - Branch completes here: pc_we=1; npc_sel=1 if taken, else 0.
//     Taken: BEQ zf, BNE !zf, BLT sf^of, BGE !(sf^of), BLTU cf, BGEU !cf.
//   - MRET completes here: pc_we=1, npc_sel=4, int_en<=1.
//  MEM: mem_req=1, mem_we=store; same ready/timeout rule as FETCH (timeout -> TRAP, cause 3).
//   - Store completes on ready: pc_we=1, npc_sel=0.
//   - Load on ready -> WB.
//  WB: rf_we=1, pc_we=1.
//   - wb_sel: 1 load, 2 JAL/JALR, else 0.
//   - npc_sel: 1 JAL, 2 JALR, else 0.
//  Completion cycle (branch, MRET, store-ready, WB):
//   - Next TRAP with cause 1 if INT=1 & int_en=1; else next FETCH.
//   - PC already holds the next instruction, so EPC = resume address.
//  Faults (illegal, bus error): pc_we is never asserted for the faulting instruction;
//   EPC = faulting PC.
//  TRAP (1 cycle): epc_we=1, pc_we=1, npc_sel=3, int_ack=(cause==1), int_en<=0, next FETCH.
//  cnt clears on every state change. MIO_ready outside FETCH/MEM is ignored.
//  Priority: bus timeout and illegal beat INT; INT is sampled only at completion cycles.
//  rst mid-instruction: aborts at once, no write enable on the reset cycle, restarts in FETCH.
// TESTING
//  1) ADD with MIO_ready=1 every FETCH -> states 0,1,2,4,0; rf_we=1 and pc_we=1 only in WB,
//     wb_sel=0, npc_sel=0.
//  2) LW with MIO_ready low 3 cycles in MEM -> mem_req held 4 cycles, no mem_we;
//     WB then has wb_sel=1.
//  3) BNE with zf=0 -> EXEC pc_we=1, npc_sel=1, then FETCH.
//     BGEU with cf=1 -> npc_sel=0.
//  4) MIO_ready stuck 0 in FETCH, MEM_TIMEOUT=16 -> TRAP on cycle 17 with cause=3,
//     epc_we=1, npc_sel=3, no ir_we.
//  5) INT=1 during WB of ADDI, int_en=1 -> TRAP with cause=1 and int_ack=1.
//     Second INT before MRET is ignored; after MRET (npc_sel=4) the next completion traps again.
//  6) Op=0000000 -> DECODE to TRAP, cause=2; rst high during MEM -> all outputs 0,
//     then FETCH with int_en=INT_EN_RST.

Source files
------------

// File: rtl/mcycle_ctrl.sv
// Multi-cycle RV32I sequencer: steps each instruction through FETCH/DECODE/EXEC/MEM/WB,
// handles the memory handshake with timeout, and takes traps for interrupts, illegal ops and bus errors.
module mcycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 5,
  parameter bit          INT_EN_RST  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] Op,
  input  logic [2:0] Funct3,
  input  logic [6:0] Funct7,
  input  logic       zf,
  input  logic       sf,
  input  logic       cf,
  input  logic       of,
  input  logic       MIO_ready,
  input  logic       INT,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_we,
  output logic       pc_we,
  output logic [2:0] npc_sel,
  output logic       rf_we,
  output logic [1:0] wb_sel,
  output logic       epc_we,
  output logic [1:0] cause,
  output logic       int_ack,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    C_ALU,
    C_LOAD,
    C_STORE,
    C_BRANCH,
    C_JAL,
    C_JALR,
    C_MRET
  } iclass_t;

  typedef enum logic [1:0] {
    CS_NONE = 2'd0,
    CS_INT  = 2'd1,
    CS_ILL  = 2'd2,
    CS_BUS  = 2'd3
  } cause_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] F7_MRET   = 7'b0011000;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t           state_q, state_n;
  iclass_t          class_q, dec_class;
  cause_t           cause_q, cause_n;
  logic [CNT_W-1:0] cnt_q;
  logic             int_en_q, int_en_n;
  logic             dec_legal;
  logic             taken;
  logic             complete;
  logic             timeout;

  logic       mem_req_c, mem_we_c, ir_we_c, pc_we_c, rf_we_c, epc_we_c, int_ack_c;
  logic [2:0] npc_sel_c;
  logic [1:0] wb_sel_c, cause_c;

  always_comb begin
    dec_class = C_ALU;
    dec_legal = 1'b1;
    case (Op)
      OP_R, OP_I, OP_LUI, OP_AUIPC: dec_class = C_ALU;
      OP_LOAD:   dec_class = C_LOAD;
      OP_STORE:  dec_class = C_STORE;
      OP_BRANCH: begin
        dec_class = C_BRANCH;
        dec_legal = (Funct3 != 3'b010) && (Funct3 != 3'b011);
      end
      OP_JAL:    dec_class = C_JAL;
      OP_JALR:   dec_class = C_JALR;
      OP_SYSTEM: begin
        dec_class = C_MRET;
        dec_legal = (Funct3 == 3'b000) && (Funct7 == F7_MRET);
      end
      default:   dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    case (Funct3)
      3'b000:  taken = zf;
      3'b001:  taken = ~zf;
      3'b100:  taken = sf ^ of;
      3'b101:  taken = ~(sf ^ of);
      3'b110:  taken = cf;
      3'b111:  taken = ~cf;
      default: taken = 1'b0;
    endcase
  end

  assign timeout = (cnt_q == CNT_LAST);

  always_comb begin
    state_n   = state_q;
    cause_n   = cause_q;
    int_en_n  = int_en_q;
    complete  = 1'b0;
    mem_req_c = 1'b0;
    mem_we_c  = 1'b0;
    ir_we_c   = 1'b0;
    pc_we_c   = 1'b0;
    rf_we_c   = 1'b0;
    epc_we_c  = 1'b0;
    int_ack_c = 1'b0;
    npc_sel_c = 3'd0;
    wb_sel_c  = 2'd0;
    cause_c   = 2'd0;
    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        if (MIO_ready) begin
          ir_we_c = 1'b1;
          state_n = S_DECODE;
        end else if (timeout) begin
          state_n = S_TRAP;
          cause_n = CS_BUS;
        end
      end
      S_DECODE: begin
        if (!dec_legal) begin
          state_n = S_TRAP;
          cause_n = CS_ILL;
        end else begin
          state_n = S_EXEC;
        end
      end
      S_EXEC: begin
        case (class_q)
          C_LOAD, C_STORE: state_n = S_MEM;
          C_BRANCH: begin
            pc_we_c   = 1'b1;
            npc_sel_c = taken ? 3'd1 : 3'd0;
            complete  = 1'b1;
          end
          C_MRET: begin
            pc_we_c   = 1'b1;
            npc_sel_c = 3'd4;
            int_en_n  = 1'b1;
            complete  = 1'b1;
          end
          default: state_n = S_WB;
        endcase
      end
      S_MEM: begin
        mem_req_c = 1'b1;
        mem_we_c  = (class_q == C_STORE);
        if (MIO_ready) begin
          if (class_q == C_STORE) begin
            pc_we_c  = 1'b1;
            complete = 1'b1;
          end else begin
            state_n = S_WB;
          end
        end else if (timeout) begin
          state_n = S_TRAP;
          cause_n = CS_BUS;
        end
      end
      S_WB: begin
        rf_we_c  = 1'b1;
        pc_we_c  = 1'b1;
        complete = 1'b1;
        case (class_q)
          C_LOAD:  wb_sel_c = 2'd1;
          C_JAL:   begin wb_sel_c = 2'd2; npc_sel_c = 3'd1; end
          C_JALR:  begin wb_sel_c = 2'd2; npc_sel_c = 3'd2; end
          default: ;
        endcase
      end
      S_TRAP: begin
        epc_we_c  = 1'b1;
        pc_we_c   = 1'b1;
        npc_sel_c = 3'd3;
        cause_c   = cause_q;
        int_ack_c = (cause_q == CS_INT);
        int_en_n  = 1'b0;
        state_n   = S_FETCH;
      end
      default: state_n = S_FETCH;
    endcase
    // Interrupts are only taken at instruction boundaries, using int_en as it stood before this cycle.
    if (complete) begin
      if (INT && int_en_q) begin
        state_n = S_TRAP;
        cause_n = CS_INT;
      end else begin
        state_n = S_FETCH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      cnt_q    <= '0;
      int_en_q <= INT_EN_RST;
      cause_q  <= CS_NONE;
      class_q  <= C_ALU;
    end else begin
      state_q  <= state_n;
      cnt_q    <= (state_n != state_q) ? '0 : cnt_q + CNT_W'(1);
      int_en_q <= int_en_n;
      cause_q  <= cause_n;
      if (state_q == S_DECODE) class_q <= dec_class;
    end
  end

  always_comb begin
    mem_req = ~rst & mem_req_c;
    mem_we  = ~rst & mem_we_c;
    ir_we   = ~rst & ir_we_c;
    pc_we   = ~rst & pc_we_c;
    rf_we   = ~rst & rf_we_c;
    epc_we  = ~rst & epc_we_c;
    int_ack = ~rst & int_ack_c;
    npc_sel = rst ? '0 : npc_sel_c;
    wb_sel  = rst ? '0 : wb_sel_c;
    cause   = rst ? '0 : cause_c;
    state   = rst ? '0 : state_q;
  end

endmodule
